// File: rtl/synth_pkg.sv
// Shared types and key-map constants for the synthesizer front end.
// The helpers cover note priority and the waveform mode sequence.
package synth_pkg;

    localparam int NUM_NOTE_KEYS = 13;
    localparam int MODE_KEY      = 13;
    localparam int SOUNDGEN_KEY  = 14;

    typedef logic [3:0] note_t;

    typedef enum logic [1:0] {
        SAW    = 2'd0,
        TRI    = 2'd1,
        SQUARE = 2'd2
    } mode_t;

    // The highest pressed key wins, so scan upward and let later hits overwrite.
    function automatic note_t highest_note(input logic [NUM_NOTE_KEYS-1:0] keys);
        note_t n;
        n = '0;
        for (int i = 0; i < NUM_NOTE_KEYS; i++) begin
            if (keys[i]) n = note_t'(i + 1);
        end
        return n;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            SAW:     return TRI;
            TRI:     return SQUARE;
            default: return SAW;
        endcase
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus one shared stability counter for the whole key vector.
// Any change on any synchronized key restarts the acceptance window for all keys.
module key_debouncer #(
    parameter int WIDTH           = 15,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_db
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync_q;
    logic [WIDTH-1:0] r_db;
    logic [CW-1:0]    r_cnt;

    logic             w_stable;
    logic             w_load;
    logic [CW-1:0]    w_cnt_next;

    assign w_stable = (r_sync2 == r_sync_q);

    // db loads on the edge where the counter reaches its terminal value, so the
    // window is exactly DEBOUNCE_CYCLES stable synchronized samples.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        w_cnt_next = '0;
        if (w_stable) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
        end
        w_load = w_stable && (w_cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_q <= '0;
            r_cnt    <= '0;
            r_db     <= '0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
            r_cnt    <= w_cnt_next;
            if (w_load) r_db <= r_sync2;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front end: debounced key vector to a priority note code, waveform mode
// cycling and a sound-generator toggle. Every output is registered.
module keypad_conditioner
    import synth_pkg::*;
#(
    parameter int NUM_KEYS        = 15,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keypad_i,
    output logic [3:0]          note_o,
    output logic                note_strobe_o,
    output logic [1:0]          mode_o,
    output logic                soundgen_o
);

    logic [NUM_KEYS-1:0] w_db;
    logic                w_mode_rise;
    logic                w_sg_rise;
    mode_t               w_mode_next;
    logic                w_soundgen_next;
    note_t               w_note_next;
    logic                w_strobe_next;

    logic                r_mode_key_q;
    logic                r_sg_key_q;
    mode_t               r_mode;
    logic                r_soundgen;
    note_t               r_note;
    logic                r_strobe;

    key_debouncer #(
        .WIDTH           (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst   (rst),
        .i_raw (keypad_i),
        .o_db  (w_db)
    );

    // Note keys are level-driven; only mode and sound-gen need an edge history.
    assign w_mode_rise = w_db[MODE_KEY]     & ~r_mode_key_q;
    assign w_sg_rise   = w_db[SOUNDGEN_KEY] & ~r_sg_key_q;

    always_comb begin
        w_mode_next     = r_mode;
        w_soundgen_next = r_soundgen;
        if (en) begin
            if (w_mode_rise) w_mode_next     = next_mode(r_mode);
            if (w_sg_rise)   w_soundgen_next = ~r_soundgen;
        end
        w_note_next   = en ? highest_note(w_db[NUM_NOTE_KEYS-1:0]) : note_t'(0);
        w_strobe_next = (w_note_next != '0) && (w_note_next != r_note);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_key_q <= 1'b0;
            r_sg_key_q   <= 1'b0;
            r_mode       <= SAW;
            r_soundgen   <= 1'b0;
            r_note       <= '0;
            r_strobe     <= 1'b0;
        end else begin
            // Edge history tracks even while disabled, so a key held across
            // enable rising is not seen as a fresh press.
            r_mode_key_q <= w_db[MODE_KEY];
            r_sg_key_q   <= w_db[SOUNDGEN_KEY];
            r_mode       <= w_mode_next;
            r_soundgen   <= w_soundgen_next;
            r_note       <= w_note_next;
            r_strobe     <= w_strobe_next;
        end
    end

    assign note_o        = r_note;
    assign note_strobe_o = r_strobe;
    assign mode_o        = r_mode;
    assign soundgen_o    = r_soundgen;

endmodule
